// File: rtl/sr_latch_driver.sv
// Sequenced write driver for an external gated SR latch: setup, gate pulse, hold, check.
// Define SR_DRV_READBACK_EN to enable Q/QN readback verification with bounded retries.
module sr_latch_driver #(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 3,
   parameter int HOLD_CYC  = 2,
   parameter int MAX_RETRY = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wrValid_i,
   input  logic wrData_i,
   output logic wrReady_o,
   output logic sN_o,
   output logic rN_o,
   output logic gN_o,
   input  logic qFb_i,
   input  logic qnFb_i,
   output logic done_o,
   output logic err_o,
   output logic qShadow_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      CHECK = 3'd4
   } state_t;

   localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
   localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
   localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
   localparam logic [2:0] MAX_R      = 3'(MAX_RETRY);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       data_q, data_d;
   logic [2:0] retryCnt_q, retryCnt_d;
   logic       retryPend_q, retryPend_d;
   logic       wrReady_q, wrReady_d;
   logic       sN_q, sN_d;
   logic       rN_q, rN_d;
   logic       gN_q, gN_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       qShadow_q, qShadow_d;
   logic       fbMatch;
   logic       drive;

`ifdef SR_DRV_READBACK_EN
   assign fbMatch = (qFb_i == data_q) && (qnFb_i == ~data_q);
`else
   logic unusedFb;
   assign fbMatch  = 1'b1;
   assign unusedFb = qFb_i ^ qnFb_i;
`endif

   // Next-state logic; feedback is judged in the last HOLD cycle so DONE/ERR land in CHECK
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 8'd1;
      data_d      = data_q;
      retryCnt_d  = retryCnt_q;
      retryPend_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      qShadow_d   = qShadow_q;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (wrValid_i && wrReady_q) begin
               state_d    = SETUP;
               data_d     = wrData_i;
               qShadow_d  = wrData_i;
               retryCnt_d = 3'd0;
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = PULSE;
               cnt_d   = 8'd0;
            end
         end
         PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = HOLD;
               cnt_d   = 8'd0;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = CHECK;
               cnt_d   = 8'd0;
               if (fbMatch) begin
                  done_d = 1'b1;
               end else if (retryCnt_q < MAX_R) begin
                  retryPend_d = 1'b1;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end
         CHECK: begin
            cnt_d = 8'd0;
            if (retryPend_q) begin
               state_d    = SETUP;
               retryCnt_d = retryCnt_q + 3'd1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // Drives derive from the upcoming state so they are registered alongside it;
      // S_N and R_N are complements of one bit, so both-low cannot occur
      drive     = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
      sN_d      = drive ? ~data_d : 1'b1;
      rN_d      = drive ? data_d : 1'b1;
      gN_d      = (state_d != PULSE);
      wrReady_d = (state_d == IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         data_q      <= 1'b0;
         retryCnt_q  <= 3'd0;
         retryPend_q <= 1'b0;
         wrReady_q   <= 1'b1;
         sN_q        <= 1'b1;
         rN_q        <= 1'b1;
         gN_q        <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         qShadow_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         retryCnt_q  <= retryCnt_d;
         retryPend_q <= retryPend_d;
         wrReady_q   <= wrReady_d;
         sN_q        <= sN_d;
         rN_q        <= rN_d;
         gN_q        <= gN_d;
         done_q      <= done_d;
         err_q       <= err_d;
         qShadow_q   <= qShadow_d;
      end
   end

   assign wrReady_o = wrReady_q;
   assign sN_o      = sN_q;
   assign rN_o      = rN_q;
   assign gN_o      = gN_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign qShadow_o = qShadow_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural gated SR latch on the feedback pins.
module tb_sr_latch_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wrValid = 1'b0;
   logic wrData = 1'b0;
   logic wrReady, sN, rN, gN, qFb, qnFb, done, err, qShadow;
   logic latchQ = 1'b0;
   logic stuck = 1'b0;
   int   passCount = 0;
   int   totalCount = 0;

   sr_latch_driver dut (
      .clk_i(clk), .rst_i(rst), .wrValid_i(wrValid), .wrData_i(wrData),
      .wrReady_o(wrReady), .sN_o(sN), .rN_o(rN), .gN_o(gN),
      .qFb_i(qFb), .qnFb_i(qnFb), .done_o(done), .err_o(err), .qShadow_o(qShadow)
   );

   always #5 clk = ~clk;

   // Transparent latch while gate is low; 'stuck' models a latch that never sets
   always @(gN or sN or rN) begin
      if (gN === 1'b0) begin
         if (sN === 1'b0) latchQ = 1'b1;
         else if (rN === 1'b0) latchQ = 1'b0;
      end
   end
   assign qFb  = stuck ? 1'b0 : latchQ;
   assign qnFb = ~qFb;

   task automatic checkOutput(input string tag, input int cyc, input logic obs, input logic exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one write; returns in cycle 0 (the cycle after the accept edge)
   task automatic applyStimulus(input logic d);
      wrValid = 1'b1;
      wrData  = d;
      tick();
      wrValid = 1'b0;
   endtask

   task automatic runCheckedWrite(input logic d, input int last, input logic expErr, input string tag);
      int ph;
      applyStimulus(d);
      for (int c = 0; c <= last; c++) begin
         ph = c % 8;
         checkOutput({tag, "_sN"}, c, sN, (ph <= 6) ? ~d : 1'b1);
         checkOutput({tag, "_rN"}, c, rN, (ph <= 6) ? d : 1'b1);
         checkOutput({tag, "_gN"}, c, gN, !(ph >= 2 && ph <= 4));
         checkOutput({tag, "_done"}, c, done, c == last);
         checkOutput({tag, "_err"}, c, err, (c == last) && expErr);
         checkOutput({tag, "_ready"}, c, wrReady, 1'b0);
         tick();
      end
      checkOutput({tag, "_idleReady"}, last + 1, wrReady, 1'b1);
      checkOutput({tag, "_idleDone"}, last + 1, done, 1'b0);
      checkOutput({tag, "_shadow"}, last + 1, qShadow, d);
   endtask

   always @(negedge clk) begin
      checkOutput("noSetResetOverlap", -1, sN | rN, 1'b1);
   end

   initial begin
      // Reset state
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_ready", 0, wrReady, 1'b1);
      checkOutput("rst_sN", 0, sN, 1'b1);
      checkOutput("rst_rN", 0, rN, 1'b1);
      checkOutput("rst_gN", 0, gN, 1'b1);
      checkOutput("rst_done", 0, done, 1'b0);
      checkOutput("rst_err", 0, err, 1'b0);
      checkOutput("rst_shadow", 0, qShadow, 1'b0);

      // Good writes of 1 then 0
      runCheckedWrite(1'b1, 7, 1'b0, "w1");
      runCheckedWrite(1'b0, 7, 1'b0, "w0");

      // Latch stuck at Q=0 while writing 1
      stuck = 1'b1;
`ifdef SR_DRV_READBACK_EN
      runCheckedWrite(1'b1, 23, 1'b1, "retry");
`else
      runCheckedWrite(1'b1, 7, 1'b0, "noReadback");
`endif
      stuck = 1'b0;

      // Reset mid-write at cycle 3, with a competing request that must be ignored
      applyStimulus(1'b1);
      tick();
      tick();
      tick();
      checkOutput("abort_gNBefore", 3, gN, 1'b0);
      rst = 1'b1;
      wrValid = 1'b1;
      wrData = 1'b1;
      tick();
      rst = 1'b0;
      wrValid = 1'b0;
      checkOutput("abort_sN", 4, sN, 1'b1);
      checkOutput("abort_rN", 4, rN, 1'b1);
      checkOutput("abort_gN", 4, gN, 1'b1);
      checkOutput("abort_ready", 4, wrReady, 1'b1);
      checkOutput("abort_shadow", 4, qShadow, 1'b0);
      for (int c = 5; c < 20; c++) begin
         checkOutput("abort_noDone", c, done, 1'b0);
         checkOutput("abort_staysIdle", c, wrReady, 1'b1);
         tick();
      end

      // Back-to-back writes with valid held; data change mid-transaction is ignored
      applyStimulus(1'b1);
      wrValid = 1'b1;
      wrData = 1'b0;
      for (int c = 0; c <= 6; c++) begin
         checkOutput("b2b_firstSN", c, sN, 1'b0);
         tick();
      end
      checkOutput("b2b_done1", 7, done, 1'b1);
      tick();
      checkOutput("b2b_idleReady", 8, wrReady, 1'b1);
      checkOutput("b2b_idleSN", 8, sN, 1'b1);
      tick();
      wrValid = 1'b0;
      checkOutput("b2b_setupSN", 9, sN, 1'b1);
      checkOutput("b2b_setupRN", 9, rN, 1'b0);
      checkOutput("b2b_setupReady", 9, wrReady, 1'b0);
      checkOutput("b2b_shadow", 9, qShadow, 1'b0);
      tick();
      tick();
      checkOutput("b2b_pulseGN", 11, gN, 1'b0);
      begin
         int budget = 0;
         while (wrReady !== 1'b1 && budget < 40) begin
            tick();
            budget++;
         end
         checkOutput("b2b_returnIdle", budget, wrReady, 1'b1);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SETUP_CYC, 2, cycles S_N/R_N are stable before the gate opens (min 1).
REQ-002 PULSE_CYC, 3, cycles G_N is held low (latch transparent) (min 1).
REQ-003 HOLD_CYC, 2, cycles S_N/R_N are held after the gate closes (min 1).
REQ-004 MAX_RETRY, 2, re-write attempts after a readback mismatch (0..7).
REQ-005 CLK  in  1  single clock; all logic is rising-edge; reset is synchronous and active-high.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 WR_VALID  in  1  write request.
REQ-008 WR_DATA  in  1  bit to store in the latch.
REQ-009 WR_READY  out  1  request accepted when high together with WR_VALID.
REQ-010 S_N  out  1  active-low set drive to the latch.
REQ-011 R_N  out  1  active-low reset drive to the latch.
REQ-012 G_N  out  1  active-low latch gate; latch is transparent while low.
REQ-013 Q_FB, QN_FB  in  1 each  latch outputs, used for readback.
REQ-014 DONE  out  1  one-cycle pulse marking transaction end.
REQ-015 ERR  out  1  valid with DONE; 1 means the final readback mismatched.
REQ-016 Q_SHADOW  out  1  last accepted WR_DATA.

Function
REQ-017 The FSM SHALL use the states IDLE, SETUP, PULSE, HOLD and CHECK; all outputs SHALL be registered.
REQ-018 WR_READY SHALL be 1 only in IDLE; an accept edge SHALL capture WR_DATA into Q_SHADOW and the transaction register, then enter SETUP.
REQ-019 Counting from accept edge as cycle 0: SETUP SHALL occupy cycles 0..SETUP_CYC-1, PULSE the next PULSE_CYC cycles, HOLD the next HOLD_CYC cycles, and CHECK exactly 1 cycle.
REQ-020 In SETUP, PULSE and HOLD: data=1 SHALL drive S_N=0 and R_N=1; data=0 SHALL drive S_N=1 and R_N=0.
REQ-021 G_N SHALL be 0 only in PULSE.
REQ-022 In IDLE and CHECK, S_N, R_N and G_N SHALL all be 1.
REQ-023 S_N=0 with R_N=0 SHALL never occur in any cycle, including reset and retry.
REQ-024 DONE SHALL pulse 1 in the final CHECK cycle; the FSM SHALL return to IDLE on the next edge, so back-to-back accepts are separated by at least one IDLE cycle.
REQ-025 WR_VALID and WR_DATA changes outside IDLE SHALL be ignored.
REQ-026 ERR SHALL be 0 whenever DONE is 0.

Reset
REQ-027 With RST high at an edge, the block SHALL enter IDLE and set S_N=R_N=G_N=1, WR_READY=1, DONE=0, ERR=0, Q_SHADOW=0, retry count=0.
REQ-028 RST SHALL take priority over any accept or state transition; a reset mid-transaction SHALL abort it with no DONE.

Configuration
REQ-029 When SR_DRV_READBACK_EN is defined, CHECK SHALL compare Q_FB==data and QN_FB==~data.
REQ-030 On a readback match, CHECK SHALL assert DONE with ERR=0.
REQ-031 On a readback mismatch with retry count < MAX_RETRY, CHECK SHALL increment the retry count, return to SETUP and not assert DONE.
REQ-032 On a readback mismatch with retry count = MAX_RETRY, CHECK SHALL assert DONE with ERR=1.
REQ-033 The retry count SHALL clear on each accept.
REQ-034 Without SR_DRV_READBACK_EN, Q_FB and QN_FB SHALL be ignored, ERR SHALL be constant 0, and every CHECK SHALL assert DONE.

Verification (defaults)
REQ-035 After reset, write 1 with correct feedback:
- S_N=0/R_N=1 in cycles 0-6;
- G_N=0 in cycles 2-4 only;
- DONE=1, ERR=0 at cycle 7;
- Q_SHADOW=1.
REQ-036 Write 0 with correct feedback:
- R_N=0/S_N=1 in cycles 0-6;
- DONE at cycle 7, ERR=0.
REQ-037 Macro on, write 1, feedback held Q_FB=0/QN_FB=1:
- three full attempts;
- no DONE at cycles 7 or 15;
- DONE=1, ERR=1 at cycle 23.
REQ-038 RST pulsed at cycle 3 of a write:
- next cycle S_N=R_N=G_N=1, WR_READY=1;
- no DONE ever issued for that write.
REQ-039 WR_VALID held high, two writes (1 then 0):
- second accept at cycle 8;
- second SETUP starts cycle 9;
- S_N/R_N never both 0 throughout.
REQ-040 Macro off, wrong feedback: DONE at cycle 7 with ERR=0 and no retry.
